car_sequencer: RTL
==================

// Module: car_sequencer
// PURPOSE
//  Microsequencer that generates CAR, the control-address input of the CPU control unit.
//  - Decodes IR at each instruction boundary (CAR_0).
//  - Steps through the CAR micro-sequence matching the instruction format and addressing modes.
//  - Inserts the interrupt entry sequence at instruction boundaries.
//  - Holds CAR during memory wait states.
//  Sits between the IR/SR registers and the control-unit word decoder.
// PARAMETERS
//  CAR_BITS   6   width of CAR; must hold encodings 0..57
// PORTS
//  clk        in   1         single system clock; all state updates on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  IR         in   16        instruction register; stable whenever CAR==CAR_0
//  gie        in   1         SR.GIE, sampled only in CAR_0
//  irq        in   1         level interrupt request from the interrupt controller
//  stall      in   1         memory wait; when high, CAR holds and no outputs pulse
//  CAR        out  CAR_BITS  current control address (registered)
//  int_ack    out  1         one-cycle pulse, asserted in the cycle CAR first equals CAR_INT0
//  illegal    out  1         one-cycle pulse, asserted in the cycle after CAR_0 decodes an undefined IR
// BEHAVIOUR
//  Reset
//   - rst_n low forces CAR=0 (CAR_0), int_ack=0, illegal=0 immediately, including mid-sequence.
//   - The first sequence starts at the first rising edge after rst_n deasserts.
//  CAR encoding (shared macros)
//   0 CAR_0; 1 REG_REG; 2-5 REG_IDX0-3; 6-7 IND_REG0-1; 8-12 IND_IDX0-4
//   13-15 IDX_REG0-2; 16-21 IDX_IDX0-5; 22 1OP_REG; 23-25 1OP_IND0-2; 26-29 1OP_IDX0-3
//   30-32 PUSH_REG0-2; 33-35 PUSH_IND0-2; 36-39 PUSH_IDX0-3; 40-42 CALL_REG0-2
//   43-45 CALL_IND0-2; 46-49 CALL_IDX0-3; 50-51 RETI0-1; 52-56 INT0-4; 57 JMP
//  Next-address rule (stall low)
//   - Non-final state of a sequence: CAR <= CAR+1.
//   - Final state of a sequence: CAR <= 0. Final states are 1,5,7,12,15,21,22,25,29,32,35,39,42,45,49,51,56,57.
//   - Codes 58..63 are unreachable; if ever present, CAR <= 0 on the next edge.
//  Decode in CAR_0
//   - irq & gie: CAR <= 52 (INT0). IR is not consumed and is decoded again in the CAR_0 that follows INT4.
//   - IR[15:13]==3'b001: jump -> 57.
//   - IR[15:10]==6'b000100: format II; op=IR[9:7].
//       op 000-011 -> 1OP_REG / 1OP_IDX / 1OP_IND by source mode.
//       op 100 -> PUSH_*; op 101 -> CALL_*.
//       op 110 -> RETI0 (50), regardless of mode bits.
//       op 111 -> illegal.
//   - IR[15:12]>=4: format I; entry chosen by {src mode, Ad}:
//       REG,0->1; REG,1->2; IND,0->6; IND,1->8; IDX,0->13; IDX,1->16.
//   - Every other IR is illegal: CAR stays 0 and illegal pulses next cycle.
//  Source mode
//   - As=00 -> REG; As=01 -> IDX; As=10 or 11 -> IND (autoincrement sequences like indirect).
//   - Constant generator overrides to REG: IR[11:8]==3 (any As), or IR[11:8]==2 with As[1]==1.
//   - IR[11:8]==2 with As=01 (absolute) remains IDX.
//  Stall
//   - stall high: CAR, int_ack and illegal all hold off; stall beats any next-address or irq decision.
//   - The decode is re-evaluated on the first edge with stall low.
//  Interrupt sampling
//   - irq arriving mid-sequence is ignored until the next CAR_0.
//   - irq is never taken inside INT0-4; a new decode happens only in CAR_0.
// TESTING
//  - IR=16'h4F0E, irq=0: CAR 0->1->0; illegal and int_ack stay 0.
//  - IR=16'h5495 (idx->idx): CAR 0,16,17,18,19,20,21,0.
//  - IR=16'h1205 / 16'h12A6 / 16'h1300 / 16'h3C00:
//      PUSH R5 -> 0,30,31,32,0
//      CALL @R6 -> 0,43,44,45,0
//      RETI -> 0,50,51,0
//      JMP -> 0,57,0
//  - irq=1, gie=1 at CAR_0 with IR=16'h4F0E: CAR 0,52..56,0,1; int_ack high exactly at 52.
//    Same case with gie=0: CAR 0,1.
//  - IR=16'h0000 and IR=16'h1380: CAR stays 0; illegal pulses one cycle each.
//    IR=16'h4302 (CG source) -> 0,1,0.
//  - stall=1 for 3 cycles at CAR=18: CAR holds 18, then continues 19.
//    rst_n low at CAR=19: CAR=0 immediately, before the next edge.

Source files
------------

// File: rtl/car_sequencer.sv
// car_sequencer
//   Microsequencer that produces CAR, the control address for the CPU control
//   unit word decoder. In CAR_0 it decodes IR (or enters the interrupt entry
//   sequence). It then walks the micro-sequence for that instruction format and
//   addressing mode, and returns to CAR_0 from each sequence's final state.
//   While stall is high it holds CAR during memory wait states.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   IR       instruction register, stable while CAR == CAR_0
//   gie      SR.GIE, sampled only in CAR_0
//   irq      level interrupt request
//   stall    memory wait: CAR holds and no output pulses
//   CAR      current control address (registered)
//   int_ack  one-cycle pulse in the first cycle CAR == INT0
//   illegal  one-cycle pulse in the cycle after CAR_0 decodes an undefined IR
module car_sequencer #(
  parameter int unsigned CAR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         IR,
  input  logic                gie,
  input  logic                irq,
  input  logic                stall,
  output logic [CAR_BITS-1:0] CAR,
  output logic                int_ack,
  output logic                illegal
);

  typedef enum logic [CAR_BITS-1:0] {
    CAR_0, REG_REG, REG_IDX0, REG_IDX1, REG_IDX2, REG_IDX3, IND_REG0, IND_REG1,
    IND_IDX0, IND_IDX1, IND_IDX2, IND_IDX3, IND_IDX4,
    IDX_REG0, IDX_REG1, IDX_REG2,
    IDX_IDX0, IDX_IDX1, IDX_IDX2, IDX_IDX3, IDX_IDX4, IDX_IDX5,
    OP1_REG, OP1_IND0, OP1_IND1, OP1_IND2, OP1_IDX0, OP1_IDX1, OP1_IDX2, OP1_IDX3,
    PUSH_REG0, PUSH_REG1, PUSH_REG2, PUSH_IND0, PUSH_IND1, PUSH_IND2,
    PUSH_IDX0, PUSH_IDX1, PUSH_IDX2, PUSH_IDX3,
    CALL_REG0, CALL_REG1, CALL_REG2, CALL_IND0, CALL_IND1, CALL_IND2,
    CALL_IDX0, CALL_IDX1, CALL_IDX2, CALL_IDX3,
    RETI0, RETI1, INT0, INT1, INT2, INT3, INT4, JMP
  } car_t;

  typedef enum logic [1:0] {M_REG, M_IDX, M_IND} mode_t;

  car_t car, nxt;
  logic ack_nxt, ill_nxt;
  mode_t mode1, mode2;

  // Byte/word select plays no part in sequencing.
  logic unused_bw;
  assign unused_bw = IR[6];

  // R2/R3 act as constant generators and are treated as register operands,
  // except R2 with As=01, which is absolute addressing and stays indexed.
  function automatic mode_t src_mode(input logic [3:0] rs, input logic [1:0] as);
    if (rs == 4'd3 || (rs == 4'd2 && as[1]))
      return M_REG;
    case (as)
      2'b00:   return M_REG;
      2'b01:   return M_IDX;
      default: return M_IND;
    endcase
  endfunction

  function automatic logic is_final(input car_t c);
    case (c)
      REG_REG, REG_IDX3, IND_REG1, IND_IDX4, IDX_REG2, IDX_IDX5, OP1_REG,
      OP1_IND2, OP1_IDX3, PUSH_REG2, PUSH_IND2, PUSH_IDX3, CALL_REG2,
      CALL_IND2, CALL_IDX3, RETI1, INT4, JMP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Format I takes its source register from IR[11:8]; the single-operand
  // format II instructions take their operand register from IR[3:0].
  assign mode1 = src_mode(IR[11:8], IR[5:4]);
  assign mode2 = src_mode(IR[3:0], IR[5:4]);

  always_comb begin
    nxt     = car;
    ack_nxt = 1'b0;
    ill_nxt = 1'b0;
    if (!stall) begin
      if (car == CAR_0) begin
        if (irq && gie) begin
          nxt     = INT0;
          ack_nxt = 1'b1;
        end else if (IR[15:13] == 3'b001) begin
          nxt = JMP;
        end else if (IR[15:10] == 6'b000100) begin
          case (IR[9:7])
            3'b100:  nxt = (mode2 == M_REG) ? PUSH_REG0 : (mode2 == M_IDX) ? PUSH_IDX0 : PUSH_IND0;
            3'b101:  nxt = (mode2 == M_REG) ? CALL_REG0 : (mode2 == M_IDX) ? CALL_IDX0 : CALL_IND0;
            3'b110:  nxt = RETI0;
            3'b111:  ill_nxt = 1'b1;
            default: nxt = (mode2 == M_REG) ? OP1_REG : (mode2 == M_IDX) ? OP1_IDX0 : OP1_IND0;
          endcase
        end else if (IR[15:14] != 2'b00) begin
          case (mode1)
            M_REG:   nxt = IR[7] ? REG_IDX0 : REG_REG;
            M_IND:   nxt = IR[7] ? IND_IDX0 : IND_REG0;
            default: nxt = IR[7] ? IDX_IDX0 : IDX_REG0;
          endcase
        end else begin
          ill_nxt = 1'b1;
        end
      end else if (car > JMP || is_final(car)) begin
        nxt = CAR_0;
      end else begin
        nxt = car_t'(car + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car     <= CAR_0;
      int_ack <= 1'b0;
      illegal <= 1'b0;
    end else begin
      car     <= nxt;
      int_ack <= ack_nxt;
      illegal <= ill_nxt;
    end
  end

  assign CAR = car;

endmodule
